// File: rtl/regfile_sb_pkg.sv
// regfile_sb shared package
// Default widths, register-zero constant, address type.
package regfile_sb_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int REG_ZERO       = 0;

   typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb bus interface
// Controller drives writes/reads/marks; the regfile answers.
interface regfile_sb_if
   import regfile_sb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = 2
);

   logic                           wen;
   logic [ADDR_WIDTH-1:0]          write_addr;
   logic [DATA_WIDTH-1:0]          write_data;
   logic [NUM_READ*ADDR_WIDTH-1:0] read_addr;
   logic [NUM_READ*DATA_WIDTH-1:0] read_data;
   logic [NUM_READ-1:0]            read_busy;
   logic                           mark;
   logic [ADDR_WIDTH-1:0]          mark_addr;
   logic                           busy_any;

   modport master (
      output wen, write_addr, write_data,
      output read_addr, mark, mark_addr,
      input  read_data, read_busy, busy_any
   );

   modport slave (
      input  wen, write_addr, write_data,
      input  read_addr, mark, mark_addr,
      output read_data, read_busy, busy_any
   );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb pending-write scoreboard
// One busy bit per register; mark sets, write clears, mark wins.
module regfile_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wen_i,
   input  logic [ADDR_WIDTH-1:0]    write_addr_i,
   input  logic                     mark_i,
   input  logic [ADDR_WIDTH-1:0]    mark_addr_i,
   output logic [2**ADDR_WIDTH-1:0] busy_o,
   output logic                     busy_any_o
);

   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

   logic [2**ADDR_WIDTH-1:0] busy_q;
   logic [2**ADDR_WIDTH-1:0] busy_d;

   // Next busy vector: clear on write, then set on mark.
   always_comb begin
      busy_d = busy_q;
      if (wen_i && write_addr_i != ZERO)
         busy_d[write_addr_i] = 1'b0;
      if (mark_i && mark_addr_i != ZERO)
         busy_d[mark_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Busy register, cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy_o     = busy_q;
   assign busy_any_o = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb top
// Register array, read muxes with optional bypass, scoreboard.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = 2,
   parameter bit BYPASS     = 1'b1
) (
   input logic         clk,
   input logic         reset,
   regfile_sb_if.slave bus
);

   localparam int NREG = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] regs_q [NREG];
   logic [NREG-1:0]       busy;

   // Storage: reset clears all, register zero never written.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= '0;
      end else if (bus.wen && bus.write_addr != ZERO) begin
         regs_q[bus.write_addr] <= bus.write_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sb (
      .clk          (clk),
      .reset        (reset),
      .wen_i        (bus.wen),
      .write_addr_i (bus.write_addr),
      .mark_i       (bus.mark),
      .mark_addr_i  (bus.mark_addr),
      .busy_o       (busy),
      .busy_any_o   (bus.busy_any)
   );

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd;

      assign ra = bus.read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Read lane: zero register, then bypass, else stored value.
      always_comb begin
         rd = regs_q[ra];
         if (ra == ZERO)
            rd = '0;
         else if (BYPASS && bus.wen && bus.write_addr == ra)
            rd = bus.write_data;
      end

      assign bus.read_data[k*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign bus.read_busy[k] = busy[ra];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// regfile_sb testbench
// Two configs driven in lockstep: bypass/2 ports and no-bypass/4 ports.
module tb_regfile_sb;
   import regfile_sb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic wen;
   reg_addr_t wa;
   logic [31:0] wd;
   logic mark;
   reg_addr_t ma;
   reg_addr_t rd [4];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) ifa ();
   regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) ifb ();

   assign ifa.wen = wen;
   assign ifa.write_addr = wa;
   assign ifa.write_data = wd;
   assign ifa.mark = mark;
   assign ifa.mark_addr = ma;
   assign ifa.read_addr = {rd[1], rd[0]};

   assign ifb.wen = wen;
   assign ifb.write_addr = wa;
   assign ifb.write_data = wd;
   assign ifb.mark = mark;
   assign ifb.mark_addr = ma;
   assign ifb.read_addr = {rd[3], rd[2], rd[1], rd[0]};

   regfile_sb #(
      .DATA_WIDTH (32), .ADDR_WIDTH (5), .NUM_READ (2), .BYPASS (1'b1)
   ) dut_a (
      .clk (clk), .reset (reset), .bus (ifa)
   );

   regfile_sb #(
      .DATA_WIDTH (32), .ADDR_WIDTH (5), .NUM_READ (4), .BYPASS (1'b0)
   ) dut_b (
      .clk (clk), .reset (reset), .bus (ifb)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] la(input int k);
      return ifa.read_data[k*32 +: 32];
   endfunction

   function automatic logic [31:0] lb(input int k);
      return ifb.read_data[k*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen = 1'b0;
      mark = 1'b0;
      wa = '0;
      ma = '0;
      wd = '0;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) rd[i] = '0;
      tick();
      reset = 1'b1;

      rd[0] = 5'd0; rd[1] = 5'd3; rd[2] = 5'd31; rd[3] = 5'd3;
      #1;
      chk("rst_a0", la(0), 32'd0);
      chk("rst_a1", la(1), 32'd0);
      chk("rst_b2", lb(2), 32'd0);
      chk("rst_b3", lb(3), 32'd0);
      chk("rst_busy_a", {31'd0, ifa.busy_any}, 32'd0);
      chk("rst_busy_b", {31'd0, ifb.busy_any}, 32'd0);
      chk("rst_rbusy_b", {28'd0, ifb.read_busy}, 32'd0);

      wen = 1'b1; wa = 5'd3; wd = 32'd123;
      rd[0] = 5'd3; rd[1] = 5'd3;
      #1;
      chk("byp_a0", la(0), 32'd123);
      chk("nobyp_b0", lb(0), 32'd0);
      tick();
      idle();
      #1;
      chk("wr_a0", la(0), 32'd123);
      chk("wr_a1", la(1), 32'd123);
      chk("wr_b0", lb(0), 32'd123);
      chk("wr_b3", lb(3), 32'd123);

      wen = 1'b1; wa = 5'd0; wd = 32'd111;
      rd[0] = 5'd0;
      #1;
      chk("z_byp_a0", la(0), 32'd0);
      tick();
      idle();
      #1;
      chk("z_a0", la(0), 32'd0);
      chk("z_b0", lb(0), 32'd0);
      chk("z_keep_a1", la(1), 32'd123);

      mark = 1'b1; ma = 5'd0;
      tick();
      idle();
      #1;
      chk("zmark_a", {31'd0, ifa.busy_any}, 32'd0);
      chk("zmark_b", {31'd0, ifb.busy_any}, 32'd0);

      rd[0] = 5'd7;
      mark = 1'b1; ma = 5'd7;
      #1;
      chk("mk_nobyp_a", {31'd0, ifa.read_busy[0]}, 32'd0);
      tick();
      idle();
      #1;
      chk("mk_rb_a", {31'd0, ifa.read_busy[0]}, 32'd1);
      chk("mk_rb_b", {31'd0, ifb.read_busy[0]}, 32'd1);
      chk("mk_any_a", {31'd0, ifa.busy_any}, 32'd1);
      chk("mk_other_a", {31'd0, ifa.read_busy[1]}, 32'd0);

      wen = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
      #1;
      chk("wb_pre_rb_a", {31'd0, ifa.read_busy[0]}, 32'd1);
      tick();
      idle();
      #1;
      chk("wb_rb_a", {31'd0, ifa.read_busy[0]}, 32'd0);
      chk("wb_any_b", {31'd0, ifb.busy_any}, 32'd0);
      chk("wb_a0", la(0), 32'hDEADBEEF);
      chk("wb_b0", lb(0), 32'hDEADBEEF);

      mark = 1'b1; ma = 5'd9;
      tick();
      idle();
      wen = 1'b1; wa = 5'd9; wd = 32'h55;
      mark = 1'b1; ma = 5'd9;
      tick();
      idle();
      rd[0] = 5'd9; rd[2] = 5'd9; rd[3] = 5'd7;
      #1;
      chk("col_a0", la(0), 32'h55);
      chk("col_rb_a", {31'd0, ifa.read_busy[0]}, 32'd1);
      chk("col_any_a", {31'd0, ifa.busy_any}, 32'd1);
      chk("col_b2", lb(2), 32'h55);
      chk("col_b3", lb(3), 32'hDEADBEEF);
      chk("col_rb_b", {28'd0, ifb.read_busy}, 32'h5);

      wen = 1'b1; wa = 5'd4; wd = 32'h20;
      tick();
      idle();
      mark = 1'b1; ma = 5'd4;
      tick();
      idle();
      rd[1] = 5'd4;
      #1;
      chk("pre_a1", la(1), 32'h20);
      chk("pre_rb_a1", {31'd0, ifa.read_busy[1]}, 32'd1);

      reset = 1'b0;
      wen = 1'b1; wa = 5'd4; wd = 32'h99;
      mark = 1'b1; ma = 5'd5;
      tick();
      reset = 1'b1;
      idle();
      #1;
      chk("rd_a1", la(1), 32'd0);
      chk("rd_b1", lb(1), 32'd0);
      chk("rd_a0", la(0), 32'd0);
      chk("rd_rb_a", {30'd0, ifa.read_busy}, 32'd0);
      chk("rd_any_a", {31'd0, ifa.busy_any}, 32'd0);
      chk("rd_any_b", {31'd0, ifb.busy_any}, 32'd0);

      wen = 1'b1; wa = 5'd6; wd = 32'hAB;
      rd[0] = 5'd6;
      tick();
      idle();
      #1;
      chk("late_a0", la(0), 32'hAB);
      chk("late_b0", lb(0), 32'hAB);
      chk("late_rb_b", {31'd0, ifb.read_busy[0]}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU register file: 2**ADDR_WIDTH x DATA_WIDTH registers, NUM_READ combinational read ports, one write port and optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard for multi-cycle bus loads, so the controller can stall on RAW hazards.
- Sits in the datapath between decode/controller and writeback.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a read of the address being written this cycle returns write_data; 0 = it returns the stored value.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 sampled on a rising clk edge clears all state.
- wen  in  1  write enable.
- write_addr  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- read_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing.
- read_busy  out  NUM_READ  port k's address has a pending write.
- mark  in  1  marks mark_addr as pending (a load has been issued).
- mark_addr  in  ADDR_WIDTH  register to mark.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (reset==0 at a posedge):
  - All registers become 0 and all busy bits become 0.
  - Reset dominates wen and mark in the same cycle.
  - Afterwards every read_data lane is 0, read_busy is 0 and busy_any is 0.
  - Reset mid-load discards the pending mark; a late write still writes normally.
- Write:
  - When wen=1 and write_addr!=0, regs[write_addr] <= write_data at the posedge.
  - The value is visible on the read ports the same cycle after the edge (combinational read).
- Register 0:
  - Always reads 0.
  - A write to it is ignored and does not affect any register.
  - mark with mark_addr=0 is ignored; busy[0] is always 0.
- Read:
  - read_data lane k = regs[read_addr_k], combinational with zero latency.
  - BYPASS=1, wen=1, write_addr==read_addr_k!=0: lane k = write_data before the edge.
  - BYPASS=0: lane k shows the old value until the edge.
- Scoreboard, per register r != 0, evaluated at each posedge:
  - busy[r] <= 1 if mark && mark_addr==r.
  - Else busy[r] <= 0 if wen && write_addr==r.
  - Else it holds.
  - Same-cycle mark and write to the same register: the write stores its data and busy ends at 1. This covers a new load reusing the register.
- Busy outputs:
  - read_busy[k] = busy[read_addr_k] and is registered state only; there is no bypass on busy.
  - busy_any = OR(busy); it is used by the controller to drain before HALT.
- Simultaneous reads: any number of ports may read the same address. A write plus N reads in one cycle has no hazard.
- Address range: full; no out-of-range addresses exist.
- Width rules: no arithmetic; data passes through unmodified.

Decomposition:
- Shared package: REG_ZERO constant (0), default DATA_WIDTH/ADDR_WIDTH localparams, and a reg_addr_t typedef logic[ADDR_WIDTH-1:0] for the default config.
- Sub-module: regfile_scoreboard, which holds the busy bit vector plus set/clear logic. The top instantiates it and the storage array, and generates the NUM_READ read muxes with a generate loop.

Test Plan:
- Reset then idle: hold reset=0 for 1 cycle, release; read ports at 0, 3, 31 -> read_data all 0, busy_any=0.
- Write/read:
  - wen=1, write_addr=3, write_data=123, read_addr port0=3, BYPASS=1 -> port0=123 before the edge.
  - After the edge with wen=0, port0=123 and port1 (addr 3)=123.
- Register zero: wen=1, write_addr=0, write_data=111 -> port0 (addr 0)=0 after the edge. mark with mark_addr=0 -> busy_any=0.
- Scoreboard:
  - mark=1, mark_addr=7 -> next cycle read_busy (addr 7)=1, busy_any=1.
  - wen=1, write_addr=7, write_data=0xDEADBEEF -> after the edge, busy=0 and data=0xDEADBEEF.
- Collision: busy[9]=1; same cycle wen to 9 with 0x55 and mark 9 -> data=0x55 and busy[9]=1.
- Reset dominance: reg 4=0x20, busy[4]=1; assert reset=0 with wen=1, write_addr=4, write_data=0x99 -> reg4=0 and busy[4]=0. Repeat the directed checks with BYPASS=0, NUM_READ=4.
